// File: rtl/serial_word_loader_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_loader_pkg
// Shared definitions for the serial word loader and the 5-bit SR-latch
// storage wrapper it drives.
//   WORD_WIDTH  : default data width of the storage block
//   state_t     : 3-bit loader FSM state encoding
//   width_min1  : clamps a computed counter width to at least one bit
// -----------------------------------------------------------------------------
package serial_word_loader_pkg;

    localparam int WORD_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_VERIFY = 3'd5,
        ST_RESP   = 3'd6
    } state_t;

    // $clog2 returns 0 for an argument of 1; a register still needs one bit.
    function automatic int width_min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/serial_word_loader_sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// Serial-in / parallel-out word register. Each loaded bit is written at the
// index given by the bit counter (LSB first), then the counter increments.
// The counter saturates at WIDTH until cleared.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous clear of word and counter (wins over load_en)
//   load_en     : store ser_in at position count and increment count
//   ser_in      : serial data bit
//   par_out     : registered assembled word
//   par_next    : value par_out will take at the next clock edge
//   count       : number of bits stored so far (0..WIDTH)
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
    parameter int WIDTH = 5,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic [WIDTH-1:0] par_next,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] par_q, par_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        par_d   = par_q;
        count_d = count_q;
        if (clear) begin
            par_d   = '0;
            count_d = '0;
        end else if (load_en && (count_q < CW'(WIDTH))) begin
            par_d[count_q] = ser_in;
            count_d        = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q   <= '0;
            count_q <= '0;
        end else begin
            par_q   <= par_d;
            count_q <= count_d;
        end
    end

    assign par_out  = par_q;
    assign par_next = par_d;
    assign count    = count_q;

endmodule

// File: rtl/serial_word_loader.sv
// -----------------------------------------------------------------------------
// serial_word_loader
// Write controller for the 5-bit SR-latch storage block. Collects WIDTH serial
// bits (LSB first) over a valid/ready handshake, presents the word to the
// latches with set-up, strobe and hold phases, reads the latch outputs back
// and reports done, or err once the retry budget is spent.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ser_valid/ser_data: serial bit stream in; ser_ready accepts it
//   mem_en, mem_wr    : storage enable (i) and write select (s0)
//   mem_d             : storage data inputs i0..i4
//   mem_q             : storage outputs o0..o4
//   busy              : high whenever the FSM is not in IDLE
//   done, err         : one-cycle result pulses (mutually exclusive)
//
// state  | meaning
// IDLE   | waiting for the first bit of a word
// SHIFT  | collecting the remaining bits, stalls on ser_valid low
// SETUP  | word driven on mem_d, strobes low (latch data set-up)
// WRITE  | mem_en/mem_wr high for WRITE_CYCLES cycles
// HOLD   | strobes low, mem_d held (latch data hold)
// VERIFY | compare mem_q with the word, retry or finish
// RESP   | done or err pulse, counters cleared
// -----------------------------------------------------------------------------
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int WIDTH        = WORD_WIDTH,
    parameter int WRITE_CYCLES = 2,
    parameter int MAX_RETRY    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_d,
    input  logic [WIDTH-1:0] mem_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int WCW = width_min1($clog2(WRITE_CYCLES));
    localparam int RCW = width_min1($clog2(MAX_RETRY + 1));

    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [RCW-1:0]   retry_q, retry_d;
    logic             ser_ready_q, ser_ready_d;
    logic             strobe_q, strobe_d;
    logic [WIDTH-1:0] mem_d_q, mem_d_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             last_bit;
    logic             shift_load;
    logic             shift_clear;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_next;
    logic [CW-1:0]    bit_cnt;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (shift_clear),
        .load_en  (shift_load),
        .ser_in   (ser_data),
        .par_out  (word),
        .par_next (word_next),
        .count    (bit_cnt)
    );

    assign accept   = ser_valid && ser_ready_q;
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        retry_d     = retry_q;
        shift_load  = 1'b0;
        shift_clear = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_SHIFT: begin
                if (accept) begin
                    shift_load = 1'b1;
                    state_d    = last_bit ? ST_SETUP : ST_SHIFT;
                end
            end
            ST_SETUP: begin
                wcnt_d  = WCW'(WRITE_CYCLES - 1);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wcnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (mem_q == word) begin
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (retry_q < RCW'(MAX_RETRY)) begin
                    retry_d = retry_q + RCW'(1);
                    state_d = ST_SETUP;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                shift_clear = 1'b1;
                retry_d     = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state register and cannot glitch.
        ser_ready_d = (state_d == ST_IDLE) || (state_d == ST_SHIFT);
        strobe_d    = (state_d == ST_WRITE);
        // The final bit lands in the shift register on the same edge that
        // enters SETUP, so load mem_d from the shift register's next value.
        mem_d_d     = (shift_load && last_bit) ? word_next : mem_d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            retry_q     <= '0;
            ser_ready_q <= 1'b0;
            strobe_q    <= 1'b0;
            mem_d_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            retry_q     <= retry_d;
            ser_ready_q <= ser_ready_d;
            strobe_q    <= strobe_d;
            mem_d_q     <= mem_d_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ser_ready = ser_ready_q;
    assign mem_en    = strobe_q;
    assign mem_wr    = strobe_q;
    assign mem_d     = mem_d_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_word_loader
// Directed bench for serial_word_loader with a behavioural SR-latch storage
// model. mode 0: normal latch; mode 1: reads 0 until the second write pulse;
// mode 2: outputs stuck at all ones.
// -----------------------------------------------------------------------------
module tb_serial_word_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_valid;
    logic       ser_data;
    logic       ser_ready;
    logic       mem_en;
    logic       mem_wr;
    logic [4:0] mem_d;
    logic [4:0] mem_q;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    int mode      = 0;
    int wr_rises  = 0;
    int wr_cycles = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    logic wr_prev = 1'b0;
    int lat;

    logic [4:0] store;

    always #5 clk = ~clk;

    always_latch begin
        if (mem_en && mem_wr) store <= mem_d;
    end

    assign mem_q = (mode == 2) ? 5'h1f :
                   ((mode == 1) && (wr_rises < 2)) ? 5'h00 : store;

    serial_word_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_d     (mem_d),
        .mem_q     (mem_q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_wr) wr_cycles++;
        if (mem_wr && !wr_prev) wr_rises++;
        wr_prev = mem_wr;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    endtask

    task automatic clear_mon();
        wr_rises  = 0;
        wr_cycles = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        both_cnt  = 0;
        wr_prev   = mem_wr;
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        ser_valid = 1'b1;
        ser_data  = b;
        while (!ser_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(ser_ready), 32'd1);
        step();
        ser_valid = 1'b0;
        ser_data  = 1'b0;
    endtask

    // Sends w LSB first with 'gap' idle cycles between bits; ser_ready must
    // stay high during those gaps.
    task automatic send_word(input logic [4:0] w, input int gap);
        for (int i = 0; i < 5; i++) begin
            send_bit(w[i]);
            if (i < 4) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk("ready_in_gap", 32'(ser_ready), 32'd1);
                end
            end
        end
    endtask

    // Counts clock edges after the last accepted bit until done or err.
    task automatic wait_resp(output int n);
        n = 0;
        while (!(done || err) && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ser_ready", 32'(ser_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_d", 32'(mem_d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        rst_n = 1'b1;
        chk("rel_ready_before_edge", 32'(ser_ready), 32'd0);
        step();
        chk("rel_ready_after_edge", 32'(ser_ready), 32'd1);

        // Basic word: bits 1,0,1,1,0 LSB first -> 5'b01101
        clear_mon();
        send_word(5'b01101, 0);
        chk("t1_setup_busy", 32'(busy), 32'd1);
        chk("t1_setup_ready", 32'(ser_ready), 32'd0);
        chk("t1_setup_mem_d", 32'(mem_d), 32'h0d);
        chk("t1_setup_mem_wr", 32'(mem_wr), 32'd0);
        wait_resp(lat);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_wr_cycles", 32'(wr_cycles), 32'd2);
        chk("t1_mem_q", 32'(mem_q), 32'h0d);
        step();
        chk("t1_done_pulse_len", 32'(done_cnt), 32'd1);
        chk("t1_err_cnt", 32'(err_cnt), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_mem_d_hold", 32'(mem_d), 32'h0d);

        // Same word with two idle cycles between bits
        clear_mon();
        send_word(5'b01101, 2);
        wait_resp(lat);
        chk("t2_latency", 32'(lat), 32'd5);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_mem_d", 32'(mem_d), 32'h0d);
        step();

        // First verify reads zero: one retry, then done
        mode = 1;
        clear_mon();
        send_word(5'b10011, 0);
        wait_resp(lat);
        chk("t3_latency", 32'(lat), 32'd10);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_attempts", 32'(wr_rises), 32'd2);
        chk("t3_wr_cycles", 32'(wr_cycles), 32'd4);
        step();
        chk("t3_err_cnt", 32'(err_cnt), 32'd0);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);

        // Storage stuck at ones: two attempts, then err
        mode = 2;
        clear_mon();
        send_word(5'b00001, 0);
        wait_resp(lat);
        chk("t4_latency", 32'(lat), 32'd10);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_attempts", 32'(wr_rises), 32'd2);
        step();
        chk("t4_err_cnt", 32'(err_cnt), 32'd1);
        chk("t4_done_cnt", 32'(done_cnt), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        mode = 0;

        // Reset asserted during WRITE
        clear_mon();
        send_word(5'b10101, 0);
        step();
        chk("t5_in_write", 32'(mem_wr), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_mem_en", 32'(mem_en), 32'd0);
        chk("t5_async_mem_wr", 32'(mem_wr), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        chk("t5_rel_busy", 32'(busy), 32'd0);
        step();
        chk("t5_rel_ready", 32'(ser_ready), 32'd1);
        clear_mon();
        send_word(5'b11010, 0);
        wait_resp(lat);
        chk("t5_latency", 32'(lat), 32'd5);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_mem_q", 32'(mem_q), 32'h1a);
        chk("t5_wr_cycles", 32'(wr_cycles), 32'd2);
        step();

        // Bits offered while busy are not consumed
        clear_mon();
        send_word(5'b00111, 0);
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t6_ready_busy", 32'(ser_ready), 32'd0);
            step();
        end
        chk("t6_done", 32'(done), 32'd1);
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        step();
        chk("t6_idle", 32'(busy), 32'd0);
        clear_mon();
        send_word(5'b01010, 0);
        chk("t6_next_mem_d", 32'(mem_d), 32'h0a);
        wait_resp(lat);
        chk("t6_next_done", 32'(done), 32'd1);
        chk("t6_next_mem_q", 32'(mem_q), 32'h0a);
        step();
        chk("t6_both_never", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
